// File: rtl/mul_rs_pkg.sv
// Shared types and constants for the multiply reservation station.
// Optional build macro: MUL_RS_OLDEST_FIRST_EN (oldest-ready dispatch order).
package mul_rs_pkg;

  localparam int XLEN       = 32;
  localparam int RS_TAG_W   = 4;
  localparam int FU_MUL_LAT = 7;

  // One reservation-station slot. exec marks the op that currently owns the multiplier.
  typedef struct packed {
    logic                busy;
    logic [RS_TAG_W-1:0] dest;
    logic                rj;
    logic                rk;
    logic [XLEN-1:0]     vj;
    logic [XLEN-1:0]     vk;
    logic [RS_TAG_W-1:0] qj;
    logic [RS_TAG_W-1:0] qk;
    logic                exec;
  } rs_entry_t;

  // Index width that stays legal for a single-entry station.
  function automatic int idx_width(input int n);
    return (n > 32'sd1) ? $clog2(n) : 32'sd1;
  endfunction

endpackage

// File: rtl/mul_rs_if.sv
// Issue / CDB / multiplier / result-buffer bundle of the multiply reservation station.
// Optional build macro: MUL_RS_OLDEST_FIRST_EN (does not change this bundle).
interface mul_rs_if
  import mul_rs_pkg::*;
#(
  parameter int TAG_W = RS_TAG_W
) ();

  logic             issue_valid;
  logic             issue_ready;
  logic [TAG_W-1:0] issue_dest;
  logic             issue_rj;
  logic             issue_rk;
  logic [XLEN-1:0]  issue_vj;
  logic [XLEN-1:0]  issue_vk;
  logic [TAG_W-1:0] issue_qj;
  logic [TAG_W-1:0] issue_qk;

  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [XLEN-1:0]  cdb_data;

  logic             fu_en;
  logic [XLEN-1:0]  fu_a;
  logic [XLEN-1:0]  fu_b;
  logic [XLEN-1:0]  fu_res;
  logic             fu_finish;

  logic             out_valid;
  logic [TAG_W-1:0] out_tag;
  logic [XLEN-1:0]  out_data;
  logic             out_grant;

  // Environment side: dispatcher, CDB, multiplier and arbiter.
  modport master (
    output issue_valid, issue_dest, issue_rj, issue_rk, issue_vj, issue_vk, issue_qj, issue_qk,
    output cdb_valid, cdb_tag, cdb_data,
    output fu_res, fu_finish, out_grant,
    input  issue_ready, fu_en, fu_a, fu_b, out_valid, out_tag, out_data
  );

  // Reservation-station side.
  modport slave (
    input  issue_valid, issue_dest, issue_rj, issue_rk, issue_vj, issue_vk, issue_qj, issue_qk,
    input  cdb_valid, cdb_tag, cdb_data,
    input  fu_res, fu_finish, out_grant,
    output issue_ready, fu_en, fu_a, fu_b, out_valid, out_tag, out_data
  );

endinterface

// File: rtl/mul_rs_pick.sv
// Ready-entry selector: one-hot grant plus binary index of the winning entry.
// Optional build macro: MUL_RS_OLDEST_FIRST_EN selects the smallest age rank
// (oldest op) instead of the lowest index.
module mul_rs_pick
  import mul_rs_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int IDX_W = idx_width(DEPTH)
) (
  input  logic [DEPTH-1:0]            ready_i,
`ifdef MUL_RS_OLDEST_FIRST_EN
  input  logic [DEPTH-1:0][IDX_W-1:0] age_i,
`endif
  output logic [DEPTH-1:0]            grant_o,
  output logic [IDX_W-1:0]            idx_o,
  output logic                        any_o
);

  logic [DEPTH-1:0] take_s;
`ifdef MUL_RS_OLDEST_FIRST_EN
  logic [IDX_W-1:0] best_age_s;
`endif

  // Scan entries and keep the current winner; ranks are unique so no tie-break is needed
  always_comb begin
    take_s = '0;
    idx_o  = '0;
    any_o  = 1'b0;
`ifdef MUL_RS_OLDEST_FIRST_EN
    best_age_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      take_s[i]  = ready_i[i] & (~any_o | (age_i[i] < best_age_s));
      idx_o      = take_s[i] ? IDX_W'(i) : idx_o;
      best_age_s = take_s[i] ? age_i[i] : best_age_s;
      any_o      = any_o | ready_i[i];
    end
`else
    for (int i = 0; i < DEPTH; i++) begin
      take_s[i] = ready_i[i] & ~any_o;
      idx_o     = take_s[i] ? IDX_W'(i) : idx_o;
      any_o     = any_o | ready_i[i];
    end
`endif
  end

  // Expand the winning index to a one-hot grant
  always_comb begin
    grant_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      grant_o[i] = any_o & (idx_o == IDX_W'(i));
    end
  end

endmodule

// File: rtl/mul_rs.sv
// Multiply reservation station: buffers issued MUL ops, wakes operands from the
// CDB, feeds one op at a time to the multiplier and holds its product until the
// CDB arbiter grants it. After reset a drain window ignores late finish pulses
// from a multiplier that was not reset.
// Optional build macro: MUL_RS_OLDEST_FIRST_EN (dispatch oldest ready op).
module mul_rs
  import mul_rs_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int TAG_W  = RS_TAG_W,
  parameter int FU_LAT = FU_MUL_LAT
) (
  input  logic     clk,
  input  logic     rst,
  mul_rs_if.slave  bus
);

  localparam int IDX_W = idx_width(DEPTH);
  localparam int DRN_W = idx_width(FU_LAT + 1);

  rs_entry_t        ent_q [DEPTH];
  rs_entry_t        ent_d [DEPTH];
  rs_entry_t        new_ent_s;
  logic             fu_busy_q, fu_busy_d;
  logic [IDX_W-1:0] exec_idx_q, exec_idx_d;
  logic [DRN_W-1:0] drain_q, drain_d;
  logic             fu_en_q, fu_en_d;
  logic [XLEN-1:0]  fu_a_q, fu_a_d;
  logic [XLEN-1:0]  fu_b_q, fu_b_d;
  logic             out_valid_q, out_valid_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic [XLEN-1:0]  out_data_q, out_data_d;

  logic [DEPTH-1:0] ready_s;
  logic [DEPTH-1:0] pick_grant_s;
  logic [IDX_W-1:0] pick_idx_s;
  logic             pick_any_s;
  logic [IDX_W-1:0] alloc_idx_s;
  logic             alloc_any_s;
  logic             issue_ready_s;
  logic             issue_fire_s;
  logic             drain_zero_s;
  logic             dispatch_s;
  logic             complete_s;

`ifdef MUL_RS_OLDEST_FIRST_EN
  logic [DEPTH-1:0][IDX_W-1:0] age_q, age_d;
  logic [IDX_W:0]              busy_cnt_s;
  logic [IDX_W-1:0]            freed_rank_s;
`endif

  function automatic logic tag_hit(input logic v, input logic [TAG_W-1:0] q,
                                   input logic [TAG_W-1:0] t);
    return v & (q == t);
  endfunction

  // Lowest free slot for allocation and per-entry dispatch readiness, from registered state
  always_comb begin
    alloc_idx_s = '0;
    alloc_any_s = 1'b0;
    ready_s     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      alloc_idx_s = (~ent_q[i].busy & ~alloc_any_s) ? IDX_W'(i) : alloc_idx_s;
      alloc_any_s = alloc_any_s | ~ent_q[i].busy;
      ready_s[i]  = ent_q[i].busy & ent_q[i].rj & ent_q[i].rk & ~ent_q[i].exec;
    end
  end

  mul_rs_pick #(.DEPTH(DEPTH)) u_pick (
    .ready_i (ready_s),
`ifdef MUL_RS_OLDEST_FIRST_EN
    .age_i   (age_q),
`endif
    .grant_o (pick_grant_s),
    .idx_o   (pick_idx_s),
    .any_o   (pick_any_s)
  );

  assign issue_ready_s   = ~rst & alloc_any_s;
  assign issue_fire_s    = bus.issue_valid & issue_ready_s;
  assign drain_zero_s    = (drain_q == '0);
  assign dispatch_s      = drain_zero_s & ~fu_busy_q & ~out_valid_q & pick_any_s;
  assign complete_s      = bus.fu_finish & fu_busy_q & drain_zero_s;
  assign bus.issue_ready = issue_ready_s;
  assign bus.fu_en       = fu_en_q;
  assign bus.fu_a        = fu_a_q;
  assign bus.fu_b        = fu_b_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_tag     = out_tag_q;
  assign bus.out_data    = out_data_q;

  // Incoming op, forwarding a same-cycle CDB broadcast so the operand is not lost
  always_comb begin
    new_ent_s      = '0;
    new_ent_s.busy = 1'b1;
    new_ent_s.dest = bus.issue_dest;
    new_ent_s.qj   = bus.issue_qj;
    new_ent_s.qk   = bus.issue_qk;
    if (!bus.issue_rj && tag_hit(bus.cdb_valid, bus.issue_qj, bus.cdb_tag)) begin
      new_ent_s.rj = 1'b1;
      new_ent_s.vj = bus.cdb_data;
    end else begin
      new_ent_s.rj = bus.issue_rj;
      new_ent_s.vj = bus.issue_vj;
    end
    if (!bus.issue_rk && tag_hit(bus.cdb_valid, bus.issue_qk, bus.cdb_tag)) begin
      new_ent_s.rk = 1'b1;
      new_ent_s.vk = bus.cdb_data;
    end else begin
      new_ent_s.rk = bus.issue_rk;
      new_ent_s.vk = bus.issue_vk;
    end
  end

  // Entry next-state: issue write, CDB snoop, dispatch mark and completion release
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      if (issue_fire_s && (alloc_idx_s == IDX_W'(i))) begin
        ent_d[i] = new_ent_s;
      end else begin
        if (ent_q[i].busy && !ent_q[i].rj && tag_hit(bus.cdb_valid, ent_q[i].qj, bus.cdb_tag)) begin
          ent_d[i].rj = 1'b1;
          ent_d[i].vj = bus.cdb_data;
        end else begin
          ent_d[i].rj = ent_q[i].rj;
        end
        if (ent_q[i].busy && !ent_q[i].rk && tag_hit(bus.cdb_valid, ent_q[i].qk, bus.cdb_tag)) begin
          ent_d[i].rk = 1'b1;
          ent_d[i].vk = bus.cdb_data;
        end else begin
          ent_d[i].rk = ent_q[i].rk;
        end
        if (complete_s && (exec_idx_q == IDX_W'(i))) begin
          ent_d[i].busy = 1'b0;
          ent_d[i].exec = 1'b0;
        end else if (dispatch_s && pick_grant_s[i]) begin
          ent_d[i].exec = 1'b1;
        end else begin
          ent_d[i].exec = ent_q[i].exec;
        end
      end
    end
  end

`ifdef MUL_RS_OLDEST_FIRST_EN
  // Age ranks: 0 is the oldest resident op; a release closes the gap above it
  always_comb begin
    busy_cnt_s   = '0;
    freed_rank_s = age_q[exec_idx_q];
    for (int i = 0; i < DEPTH; i++) begin
      busy_cnt_s = busy_cnt_s + {{IDX_W{1'b0}}, ent_q[i].busy};
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (issue_fire_s && (alloc_idx_s == IDX_W'(i))) begin
        age_d[i] = IDX_W'(busy_cnt_s - {{IDX_W{1'b0}}, complete_s});
      end else if (complete_s && ent_q[i].busy && (age_q[i] > freed_rank_s)) begin
        age_d[i] = age_q[i] - IDX_W'(1);
      end else begin
        age_d[i] = age_q[i];
      end
    end
  end
`endif

  // Drain countdown, multiplier handoff and result buffer next-state
  always_comb begin
    drain_d     = drain_zero_s ? drain_q : (drain_q - DRN_W'(1));
    fu_en_d     = dispatch_s;
    fu_a_d      = fu_a_q;
    fu_b_d      = fu_b_q;
    fu_busy_d   = fu_busy_q;
    exec_idx_d  = exec_idx_q;
    out_valid_d = out_valid_q;
    out_tag_d   = out_tag_q;
    out_data_d  = out_data_q;
    if (dispatch_s) begin
      fu_a_d     = ent_q[pick_idx_s].vj;
      fu_b_d     = ent_q[pick_idx_s].vk;
      fu_busy_d  = 1'b1;
      exec_idx_d = pick_idx_s;
    end else if (complete_s) begin
      fu_busy_d = 1'b0;
    end else begin
      fu_busy_d = fu_busy_q;
    end
    if (complete_s) begin
      out_valid_d = 1'b1;
      out_tag_d   = ent_q[exec_idx_q].dest;
      out_data_d  = bus.fu_res;
    end else if (out_valid_q && bus.out_grant) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers with synchronous reset; drain reloads to cover a late finish
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      fu_busy_q   <= 1'b0;
      exec_idx_q  <= '0;
      drain_q     <= DRN_W'(FU_LAT);
      fu_en_q     <= 1'b0;
      fu_a_q      <= '0;
      fu_b_q      <= '0;
      out_valid_q <= 1'b0;
      out_tag_q   <= '0;
      out_data_q  <= '0;
`ifdef MUL_RS_OLDEST_FIRST_EN
      age_q       <= '0;
`endif
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
      fu_busy_q   <= fu_busy_d;
      exec_idx_q  <= exec_idx_d;
      drain_q     <= drain_d;
      fu_en_q     <= fu_en_d;
      fu_a_q      <= fu_a_d;
      fu_b_q      <= fu_b_d;
      out_valid_q <= out_valid_d;
      out_tag_q   <= out_tag_d;
      out_data_q  <= out_data_d;
`ifdef MUL_RS_OLDEST_FIRST_EN
      age_q       <= age_d;
`endif
    end
  end

endmodule

// File: tb/tb_mul_rs.sv
// Self-checking bench for mul_rs: a slot-level behavioural model compared on
// every negedge, plus directed scenarios with hand-computed expectations.
module tb_mul_rs;

  localparam int DEPTH  = 2;
  localparam int TAG_W  = 4;
  localparam int FU_LAT = 7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mul_rs_if #(.TAG_W(TAG_W)) bus();
  mul_rs #(.DEPTH(DEPTH), .TAG_W(TAG_W), .FU_LAT(FU_LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: slots, multiplier owner, result buffer
  bit          m_busy [DEPTH];
  bit          m_ra   [DEPTH];
  bit          m_rb   [DEPTH];
  bit          m_exec [DEPTH];
  logic [31:0] m_a    [DEPTH];
  logic [31:0] m_b    [DEPTH];
  logic [3:0]  m_dest [DEPTH];
  logic [3:0]  m_qa   [DEPTH];
  logic [3:0]  m_qb   [DEPTH];
  bit          m_fub, m_fen, m_ov;
  int          m_eidx, m_drain;
  logic [31:0] m_fa, m_fb, m_od;
  logic [3:0]  m_ot;

  always @(posedge clk) begin : model
    int slot, pick;
    bit disp, comp;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin m_busy[i] = 0; m_exec[i] = 0; end
      m_fub = 0; m_eidx = 0; m_drain = FU_LAT; m_fen = 0;
      m_fa = 0; m_fb = 0; m_ov = 0; m_ot = 0; m_od = 0;
    end else begin
      slot = -1; pick = -1;
      for (int i = 0; i < DEPTH; i++) begin
        if (!m_busy[i] && slot < 0) slot = i;
        if (m_busy[i] && m_ra[i] && m_rb[i] && !m_exec[i] && pick < 0) pick = i;
      end
      disp = (m_drain == 0) && !m_fub && !m_ov && (pick >= 0);
      comp = bus.fu_finish && m_fub && (m_drain == 0);
      if (m_drain > 0) m_drain--;
      m_fen = disp;
      if (disp) begin
        m_fa = m_a[pick]; m_fb = m_b[pick]; m_exec[pick] = 1; m_fub = 1; m_eidx = pick;
      end
      if (m_ov && bus.out_grant) m_ov = 0;
      if (comp) begin
        m_ov = 1; m_od = bus.fu_res; m_ot = m_dest[m_eidx];
        m_busy[m_eidx] = 0; m_exec[m_eidx] = 0; m_fub = 0;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (m_busy[i] && bus.cdb_valid) begin
          if (!m_ra[i] && m_qa[i] == bus.cdb_tag) begin m_a[i] = bus.cdb_data; m_ra[i] = 1; end
          if (!m_rb[i] && m_qb[i] == bus.cdb_tag) begin m_b[i] = bus.cdb_data; m_rb[i] = 1; end
        end
      end
      if (bus.issue_valid && slot >= 0) begin
        m_busy[slot] = 1; m_exec[slot] = 0; m_dest[slot] = bus.issue_dest;
        m_ra[slot] = bus.issue_rj; m_a[slot] = bus.issue_vj; m_qa[slot] = bus.issue_qj;
        m_rb[slot] = bus.issue_rk; m_b[slot] = bus.issue_vk; m_qb[slot] = bus.issue_qk;
        if (!bus.issue_rj && bus.cdb_valid && bus.issue_qj == bus.cdb_tag) begin
          m_ra[slot] = 1; m_a[slot] = bus.cdb_data;
        end
        if (!bus.issue_rk && bus.cdb_valid && bus.issue_qk == bus.cdb_tag) begin
          m_rb[slot] = 1; m_b[slot] = bus.cdb_data;
        end
      end
    end
  end

  // ---------------- per-cycle compare against the model
  always @(negedge clk) begin : compare
    bit exp_ready;
    if (chk_on) begin
      exp_ready = 0;
      for (int i = 0; i < DEPTH; i++) if (!m_busy[i]) exp_ready = 1;
      exp_ready = exp_ready && !rst;
      check("issue_ready", {31'd0, bus.issue_ready}, {31'd0, exp_ready});
      check("fu_en", {31'd0, bus.fu_en}, {31'd0, m_fen});
      check("fu_a", bus.fu_a, m_fa);
      check("fu_b", bus.fu_b, m_fb);
      check("out_valid", {31'd0, bus.out_valid}, {31'd0, m_ov});
      check("out_tag", {28'd0, bus.out_tag}, {28'd0, m_ot});
      check("out_data", bus.out_data, m_od);
    end
  end

  // ---------------- stimulus helpers
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bus.issue_valid = 0; bus.issue_dest = 0; bus.issue_rj = 0; bus.issue_rk = 0;
    bus.issue_vj = 0; bus.issue_vk = 0; bus.issue_qj = 0; bus.issue_qk = 0;
    bus.cdb_valid = 0; bus.cdb_tag = 0; bus.cdb_data = 0;
    bus.fu_res = 0; bus.fu_finish = 0; bus.out_grant = 0;
  endtask

  task automatic issue(input logic [3:0] dest, input logic rj, input logic [31:0] vj,
                       input logic [3:0] qj, input logic rk, input logic [31:0] vk,
                       input logic [3:0] qk);
    bus.issue_valid = 1; bus.issue_dest = dest;
    bus.issue_rj = rj; bus.issue_vj = vj; bus.issue_qj = qj;
    bus.issue_rk = rk; bus.issue_vk = vk; bus.issue_qk = qk;
  endtask

  task automatic cdb(input logic [3:0] tag, input logic [31:0] data);
    bus.cdb_valid = 1; bus.cdb_tag = tag; bus.cdb_data = data;
  endtask

  task automatic wait_fu_en(input int max, output int n);
    n = 0;
    while (bus.fu_en !== 1'b1 && n < max) begin tick(); n++; end
    check("fu_en_seen", {31'd0, bus.fu_en}, 32'd1);
  endtask

  task automatic finish_op(input logic [31:0] res);
    bus.fu_finish = 1; bus.fu_res = res;
    tick();
    bus.fu_finish = 0; bus.fu_res = 0;
  endtask

  task automatic grant();
    bus.out_grant = 1;
    tick();
    bus.out_grant = 0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    rst = 1; idle();
    tick(); tick();
    chk_on = 1;
    check("reset issue_ready", {31'd0, bus.issue_ready}, 32'd0);
    check("reset fu_en", {31'd0, bus.fu_en}, 32'd0);
    check("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("reset fu_a", bus.fu_a, 32'd0);
    check("reset out_data", bus.out_data, 32'd0);

    // Post-reset drain: op ready at cycle 1, dispatch only after the window
    rst = 0;
    issue(4'd1, 1, 32'd3, 4'd0, 1, 32'd5, 4'd0);
    tick(); bus.issue_valid = 0;
    check("drain no dispatch", {31'd0, bus.fu_en}, 32'd0);
    wait_fu_en(20, n);
    check("drain latency", n + 1, 32'd8);
    check("drain fu_a", bus.fu_a, 32'd3);
    check("drain fu_b", bus.fu_b, 32'd5);
    tick();
    check("fu_en one cycle", {31'd0, bus.fu_en}, 32'd0);
    check("fu_a held", bus.fu_a, 32'd3);
    finish_op(32'd15);
    check("t1 out_valid", {31'd0, bus.out_valid}, 32'd1);
    check("t1 out_data", bus.out_data, 32'd15);
    check("t1 out_tag", {28'd0, bus.out_tag}, 32'd1);
    grant();
    check("t1 granted", {31'd0, bus.out_valid}, 32'd0);

    // CDB wakeup: captured in cycle N, dispatched in N+1
    issue(4'd3, 0, 32'd0, 4'd2, 1, 32'd4, 4'd0);
    tick(); bus.issue_valid = 0;
    cdb(4'd2, 32'hFFFF_FFFF);
    tick(); bus.cdb_valid = 0;
    check("wakeup not early", {31'd0, bus.fu_en}, 32'd0);
    tick();
    check("wakeup fu_en", {31'd0, bus.fu_en}, 32'd1);
    check("wakeup fu_a", bus.fu_a, 32'hFFFF_FFFF);
    check("wakeup fu_b", bus.fu_b, 32'd4);
    finish_op(32'hFFFF_FFFC);
    check("wakeup out_data", bus.out_data, 32'hFFFF_FFFC);
    check("wakeup out_tag", {28'd0, bus.out_tag}, 32'd3);
    grant();

    // Same-cycle issue and matching broadcast
    issue(4'd4, 0, 32'd0, 4'd5, 1, 32'd2, 4'd0);
    cdb(4'd5, 32'd9);
    tick(); bus.issue_valid = 0; bus.cdb_valid = 0;
    tick();
    check("samecyc fu_en", {31'd0, bus.fu_en}, 32'd1);
    check("samecyc fu_a", bus.fu_a, 32'd9);
    check("samecyc fu_b", bus.fu_b, 32'd2);
    finish_op(32'd18);
    check("samecyc out_data", bus.out_data, 32'd18);
    check("samecyc out_tag", {28'd0, bus.out_tag}, 32'd4);
    grant();

    // Output backpressure with a second ready op waiting
    issue(4'd6, 1, 32'd2, 4'd0, 1, 32'd3, 4'd0);
    tick(); bus.issue_valid = 0;
    wait_fu_en(5, n);
    issue(4'd7, 1, 32'd4, 4'd0, 1, 32'd5, 4'd0);
    finish_op(32'd6);
    bus.issue_valid = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp no dispatch", {31'd0, bus.fu_en}, 32'd0);
      check("bp out_valid", {31'd0, bus.out_valid}, 32'd1);
      check("bp out_data", bus.out_data, 32'd6);
      check("bp out_tag", {28'd0, bus.out_tag}, 32'd6);
    end
    grant();
    check("bp released", {31'd0, bus.out_valid}, 32'd0);
    check("bp not yet", {31'd0, bus.fu_en}, 32'd0);
    tick();
    check("bp dispatch", {31'd0, bus.fu_en}, 32'd1);
    check("bp fu_a", bus.fu_a, 32'd4);
    check("bp fu_b", bus.fu_b, 32'd5);
    finish_op(32'd20);
    check("bp out_data2", bus.out_data, 32'd20);
    grant();

    // Full station and spurious finish
    issue(4'd8, 0, 32'd0, 4'd9, 1, 32'd3, 4'd0);
    tick();
    issue(4'd9, 0, 32'd0, 4'd10, 1, 32'd5, 4'd0);
    tick(); bus.issue_valid = 0;
    check("full issue_ready", {31'd0, bus.issue_ready}, 32'd0);
    issue(4'd11, 1, 32'd100, 4'd0, 1, 32'd100, 4'd0);
    tick(); bus.issue_valid = 0;
    bus.fu_finish = 1; bus.fu_res = 32'd123;
    tick(); bus.fu_finish = 0; bus.fu_res = 0;
    check("spurious out_valid", {31'd0, bus.out_valid}, 32'd0);
    tick();
    check("full no dispatch", {31'd0, bus.fu_en}, 32'd0);
    cdb(4'd9, 32'd2);
    tick(); bus.cdb_valid = 0;
    tick();
    check("full op1 fu_a", bus.fu_a, 32'd2);
    check("full op1 fu_b", bus.fu_b, 32'd3);
    finish_op(32'd6);
    check("full op1 tag", {28'd0, bus.out_tag}, 32'd8);
    grant();
    cdb(4'd10, 32'd7);
    tick(); bus.cdb_valid = 0;
    tick();
    check("full op2 fu_a", bus.fu_a, 32'd7);
    check("full op2 fu_b", bus.fu_b, 32'd5);
    finish_op(32'd35);
    check("full op2 tag", {28'd0, bus.out_tag}, 32'd9);
    grant();
    repeat (3) tick();
    check("third op dropped", {31'd0, bus.fu_en}, 32'd0);

    // Reset mid-operation, stale finish inside the drain window
    issue(4'd2, 1, 32'd5, 4'd0, 1, 32'd6, 4'd0);
    tick(); bus.issue_valid = 0;
    wait_fu_en(5, n);
    check("midop fu_a", bus.fu_a, 32'd5);
    repeat (3) tick();
    rst = 1; #1;
    check("rst issue_ready", {31'd0, bus.issue_ready}, 32'd0);
    tick(); rst = 0;
    check("midop cleared fu_a", bus.fu_a, 32'd0);
    repeat (2) tick();
    bus.fu_finish = 1; bus.fu_res = 32'd30;
    tick(); bus.fu_finish = 0; bus.fu_res = 0;
    check("stale finish ignored", {31'd0, bus.out_valid}, 32'd0);
    repeat (10) tick();
    check("midop no result", {31'd0, bus.out_valid}, 32'd0);
    check("midop no dispatch", {31'd0, bus.fu_en}, 32'd0);
    check("midop ready", {31'd0, bus.issue_ready}, 32'd1);

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
